// File: rtl/ga25_sdr_responder.sv
// GA25 graphics-ROM responder: serves toggle requests with 2/4-word 16-bit bursts from a word-wide RAM port.
// Optional one-line 64-bit read buffer enabled by defining GA25_SDR_LINEBUF_EN.
module ga25_sdr_responder #(
   parameter int unsigned       ADDR_W = 25,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] sdr_addr,
   input  logic              sdr_req,
   input  logic              sdr_64bit,
   output logic [63:0]       sdr_data,
   output logic              sdr_rdy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic              ram_ack,
   input  logic [15:0]       ram_q,
   output logic              busy
);

   localparam int unsigned TAG_W = ADDR_W - 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              lvl, lvl_nxt;
   logic              is64, is64_nxt;
   logic [ADDR_W-1:0] a_q, a_nxt;
   logic [ADDR_W-1:0] acc_a, acc_al;
   logic [ADDR_W-1:0] ram_addr_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic [63:0]       words, words_nxt;
   logic [63:0]       sdr_data_nxt;
   logic              sdr_rdy_nxt, ram_rd_nxt, busy_nxt, last;

`ifdef GA25_SDR_LINEBUF_EN
   logic              lb_valid, lb_valid_nxt;
   logic [TAG_W-1:0]  lb_tag, lb_tag_nxt;
   logic [63:0]       lb_line, lb_line_nxt;
   logic              lb_hit;
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         lvl      <= 1'b0;
         is64     <= 1'b0;
         a_q      <= '0;
         cnt      <= '0;
         words    <= '0;
         sdr_data <= '0;
         sdr_rdy  <= 1'b0;
         ram_addr <= '0;
         ram_rd   <= 1'b0;
         busy     <= 1'b0;
`ifdef GA25_SDR_LINEBUF_EN
         lb_valid <= 1'b0;
         lb_tag   <= '0;
         lb_line  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         lvl      <= lvl_nxt;
         is64     <= is64_nxt;
         a_q      <= a_nxt;
         cnt      <= cnt_nxt;
         words    <= words_nxt;
         sdr_data <= sdr_data_nxt;
         sdr_rdy  <= sdr_rdy_nxt;
         ram_addr <= ram_addr_nxt;
         ram_rd   <= ram_rd_nxt;
         busy     <= busy_nxt;
`ifdef GA25_SDR_LINEBUF_EN
         lb_valid <= lb_valid_nxt;
         lb_tag   <= lb_tag_nxt;
         lb_line  <= lb_line_nxt;
`endif
      end
   end

   // Next-state, burst sequencing and word packing
   always_comb begin
      state_nxt    = state;
      lvl_nxt      = lvl;
      is64_nxt     = is64;
      a_nxt        = a_q;
      cnt_nxt      = cnt;
      words_nxt    = words;
      sdr_data_nxt = sdr_data;
      sdr_rdy_nxt  = sdr_rdy;
      ram_addr_nxt = ram_addr;
      ram_rd_nxt   = ram_rd;
      busy_nxt     = busy;
`ifdef GA25_SDR_LINEBUF_EN
      lb_valid_nxt = lb_valid;
      lb_tag_nxt   = lb_tag;
      lb_line_nxt  = lb_line;
`endif

      // 64b bursts align to 8 bytes, 32b to 4 bytes; sum wraps at ADDR_W
      acc_a  = sdr_addr + BASE;
      acc_al = acc_a & ~ADDR_W'({sdr_64bit, 2'b11});
      last   = is64 ? (cnt == 2'd3) : (cnt == 2'd1);
`ifdef GA25_SDR_LINEBUF_EN
      lb_hit = lb_valid && (lb_tag == acc_a[ADDR_W-1:3]);
`endif

      unique case (state)
         IDLE: begin
            if (sdr_req != sdr_rdy) begin
               lvl_nxt  = sdr_req;
               is64_nxt = sdr_64bit;
               a_nxt    = acc_al;
               cnt_nxt  = 2'd0;
               busy_nxt = 1'b1;
`ifdef GA25_SDR_LINEBUF_EN
               if (lb_hit) begin
                  state_nxt = DONE;
                  words_nxt = sdr_64bit ? lb_line
                                        : {32'h0, (acc_a[2] ? lb_line[63:32] : lb_line[31:0])};
               end else
`endif
               begin
                  state_nxt    = READ;
                  ram_rd_nxt   = 1'b1;
                  ram_addr_nxt = acc_al;
               end
            end
         end
         READ: begin
            if (ram_ack) begin
               words_nxt[{cnt, 4'b0000} +: 16] = ram_q;
               if (last) begin
                  ram_rd_nxt = 1'b0;
                  state_nxt  = DONE;
               end else begin
                  cnt_nxt      = cnt + 2'd1;
                  ram_addr_nxt = a_q + ADDR_W'({cnt_nxt, 1'b0});
               end
            end
         end
         DONE: begin
            sdr_data_nxt = is64 ? words : {32'h0, words[31:0]};
            sdr_rdy_nxt  = lvl;
            busy_nxt     = 1'b0;
            state_nxt    = IDLE;
`ifdef GA25_SDR_LINEBUF_EN
            if (is64) begin
               lb_valid_nxt = 1'b1;
               lb_tag_nxt   = a_q[ADDR_W-1:3];
               lb_line_nxt  = words;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ga25_sdr_responder.sv
// Randomized self-checking bench for ga25_sdr_responder with a transaction-level reference model.
// Expectations follow GA25_SDR_LINEBUF_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_ga25_sdr_responder;

   localparam logic [24:0] BASE = 25'h1FFFFF8;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic [24:0] sdr_addr  = '0;
   logic        sdr_req   = 1'b0;
   logic        sdr_64bit = 1'b0;
   logic [63:0] sdr_data;
   logic        sdr_rdy;
   logic [24:0] ram_addr;
   logic        ram_rd;
   logic        ram_ack   = 1'b0;
   logic [15:0] ram_q     = '0;
   logic        busy;

   int          errors    = 0;
   int          checks    = 0;
   int          cur_waits = 0;
   int          wcnt      = 0;
   bit          junk_ack  = 1'b0;
   logic [24:0] acked[$];
   logic [15:0] mem [logic [24:0]];

   // Reference model state: expected handshake level, visible data, line buffer
   logic        lvl_exp   = 1'b0;
   logic [63:0] prev_data = '0;
   bit          lb_v      = 1'b0;
   logic [24:0] lb_a      = '0;
   logic [63:0] lb_line   = '0;

   ga25_sdr_responder #(.ADDR_W(25), .BASE(BASE)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sdr_addr  (sdr_addr),
      .sdr_req   (sdr_req),
      .sdr_64bit (sdr_64bit),
      .sdr_data  (sdr_data),
      .sdr_rdy   (sdr_rdy),
      .ram_addr  (ram_addr),
      .ram_rd    (ram_rd),
      .ram_ack   (ram_ack),
      .ram_q     (ram_q),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_mem(input logic [24:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'(a[24:1] * 7) ^ 16'hC35A;
   endfunction

   // RAM model: decides ack for the coming edge; junk acks while ram_rd is low
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_ack = 1'b0;
         wcnt    = 0;
      end else if (ram_rd) begin
         if (wcnt >= cur_waits) begin
            ram_ack = 1'b1;
            ram_q   = rd_mem(ram_addr);
            acked.push_back(ram_addr);
            wcnt    = 0;
         end else begin
            ram_ack = 1'b0;
            ram_q   = 16'($urandom);
            wcnt    = wcnt + 1;
         end
      end else begin
         ram_ack = junk_ack ? 1'($urandom) : 1'b0;
         ram_q   = 16'($urandom);
         wcnt    = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request; optionally re-toggles req while busy to queue a follow-on request
   task automatic do_req(input logic [24:0] raw, input logic is64, input int waits,
                         input bit toggle, input bit chain, input logic [24:0] nraw, input logic n64);
      logic [24:0] a_raw, a;
      logic [63:0] exp;
      logic [24:0] exp_addr[$];
      bit          hit;
      int          nw, exp_lat, n;
      a_raw = raw + BASE;
      a     = a_raw & ~(is64 ? 25'd7 : 25'd3);
      nw    = is64 ? 4 : 2;
`ifdef GA25_SDR_LINEBUF_EN
      hit = lb_v && (a_raw[24:3] == lb_a[24:3]);
`else
      hit = 1'b0;
`endif
      exp = '0;
      if (hit) begin
         exp_lat = 2;
         if (is64) exp = lb_line;
         else      exp = a_raw[2] ? {32'h0, lb_line[63:32]} : {32'h0, lb_line[31:0]};
      end else begin
         exp_lat = 2 + nw * (waits + 1);
         for (int k = 0; k < nw; k++) begin
            exp_addr.push_back(a + 25'(2 * k));
            exp = exp | (64'(rd_mem(a + 25'(2 * k))) << (16 * k));
         end
      end

      cur_waits = waits;
      acked.delete();
      sdr_addr  = raw;
      sdr_64bit = is64;
      if (toggle) sdr_req = ~sdr_req;
      lvl_exp = sdr_req;

      n = 0;
      while (n < 300) begin
         @(posedge clk); #1;
         n++;
         if (sdr_rdy === lvl_exp) break;
         check("busy", 64'(busy), 64'd1);
         check("hold", sdr_data, prev_data);
         if (n == 1) begin
            if (chain) begin
               sdr_req   = ~sdr_req;
               sdr_addr  = nraw;
               sdr_64bit = n64;
            end else begin
               sdr_addr  = 25'($urandom);
               sdr_64bit = 1'($urandom);
            end
         end
      end
      check("latency", 64'(n), 64'(exp_lat));
      check("data", sdr_data, exp);
      check("busy_end", 64'(busy), 64'd0);
      check("nreads", 64'(acked.size()), 64'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < acked.size(); i++)
         check("addr", 64'(acked[i]), 64'(exp_addr[i]));

      prev_data = exp;
      if (is64) begin
         lb_v    = 1'b1;
         lb_a    = a;
         lb_line = exp;
      end
   endtask

   initial begin
      logic [24:0] r, nr, nraw_p;
      logic        s64, n64, n64_p;
      bit          ch, pend;

      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", 64'(sdr_rdy), 64'd0);
      check("rst_data", sdr_data, 64'd0);
      check("rst_rd", 64'(ram_rd), 64'd0);
      check("rst_addr", 64'(ram_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(negedge clk) reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Directed 64b burst with known words
      mem[25'h108] = 16'h1111;
      mem[25'h10A] = 16'h2222;
      mem[25'h10C] = 16'h3333;
      mem[25'h10E] = 16'h4444;
      do_req(25'(25'h108 - BASE), 1'b1, 0, 1'b1, 1'b0, '0, 1'b0);
      check("t64_data", sdr_data, 64'h4444_3333_2222_1111);

      // 32b with wait states; no second completion afterwards
      do_req(25'(25'h20E - BASE), 1'b0, 2, 1'b1, 1'b0, '0, 1'b0);
      check("t32_upper", 64'(sdr_data[63:32]), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check("t32_rdy_stable", 64'(sdr_rdy), 64'(lvl_exp));

      // Reset in the middle of a 64b burst
      cur_waits = 0;
      acked.delete();
      sdr_addr  = 25'(25'h600 - BASE);
      sdr_64bit = 1'b1;
      sdr_req   = ~sdr_req;
      for (int n = 0; n < 50 && acked.size() < 2; n++) begin
         @(posedge clk); #1;
      end
      check("rst_acks", 64'(acked.size()), 64'd2);
      #2 reset_n = 1'b0;
      #1;
      check("abort_rd", 64'(ram_rd), 64'd0);
      check("abort_rdy", 64'(sdr_rdy), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      sdr_req   = 1'b0;
      lvl_exp   = 1'b0;
      prev_data = '0;
      lb_v      = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_rdy", 64'(sdr_rdy), 64'd0);
      do_req(25'(25'h600 - BASE), 1'b1, 0, 1'b1, 1'b0, '0, 1'b0);

      // Back-to-back, then a re-toggle while busy
      do_req(25'(25'h1230 - BASE), 1'b1, 1, 1'b1, 1'b0, '0, 1'b0);
      do_req(25'(25'h4442 - BASE), 1'b0, 0, 1'b1, 1'b1, 25'(25'h7770 - BASE), 1'b1);
      do_req(25'(25'h7770 - BASE), 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);

      // Address wrap through BASE
      do_req(25'h0, 1'b1, 0, 1'b1, 1'b0, '0, 1'b0);
      do_req(25'h0000_00C, 1'b0, 1, 1'b1, 1'b0, '0, 1'b0);

      // Line buffer sequence
      do_req(25'(25'h400 - BASE), 1'b1, 0, 1'b1, 1'b0, '0, 1'b0);
      do_req(25'(25'h404 - BASE), 1'b0, 0, 1'b1, 1'b0, '0, 1'b0);

      // Randomized traffic
      pend   = 1'b0;
      nraw_p = '0;
      n64_p  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (pend) begin
            r   = nraw_p;
            s64 = n64_p;
         end else begin
            r   = ($urandom_range(0, 3) == 0) ? 25'(32'h400 + $urandom_range(0, 7) - 32'(BASE))
                                               : 25'($urandom);
            s64 = 1'($urandom);
         end
         nr       = ($urandom_range(0, 1) == 0) ? 25'($urandom) : 25'(32'h400 - 32'(BASE));
         n64      = 1'($urandom);
         ch       = ($urandom_range(0, 3) == 0);
         junk_ack = 1'($urandom);
         do_req(r, s64, int'($urandom_range(0, 2)), !pend, ch, nr, n64);
         pend   = ch;
         nraw_p = nr;
         n64_p  = n64;
      end
      if (pend) do_req(nraw_p, n64_p, 0, 1'b0, 1'b0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
